// File: rtl/servo_pwm_decoder_if.sv
// servo_pwm_decoder_if: PWM input pin and measurement results of the servo PWM decoder.
// master drives the pin and consumes results; slave is the decoder.
interface servo_pwm_decoder_if #(
    parameter int CW = 22
);
    logic          pwm_in;
    logic [CW-1:0] pulse_width;
    logic [CW-1:0] period;
    logic [7:0]    angle;
    logic          valid;
    logic          range_err;
    logic          signal_lost;

    modport master (output pwm_in, input pulse_width, period, angle, valid, range_err, signal_lost);
    modport slave (input pwm_in, output pulse_width, period, angle, valid, range_err, signal_lost);
endinterface

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures RC-servo PWM high time and period and converts the width to 0..180 degrees.
// Define SERVO_DEC_GLITCH_FILTER_EN to add a FILT_LEN-sample glitch filter behind the synchronizer.
module servo_pwm_decoder #(
    parameter int MIN_PULSE = 100000,
    parameter int MAX_PULSE = 200000,
    parameter int TIMEOUT   = 2500000,
    parameter int CW        = 22,
    parameter int FILT_LEN  = 4
) (
    input logic                clk,
    input logic                rst,
    servo_pwm_decoder_if.slave bus_io
);
    localparam int DW = CW + 8;
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
    localparam logic [CW-1:0] MINP = CW'(MIN_PULSE);
    localparam logic [CW-1:0] MAXP = CW'(MAX_PULSE);
    localparam logic [DW-1:0] SPAN = DW'(MAX_PULSE - MIN_PULSE);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LOST} state_t;

    state_t        state_q;
    logic          sync1_q, sync2_q, prev_q, line, rise, fall;
    logic [CW-1:0] hi_cnt_q, per_cnt_q, hi_lat_q, hi_pend_q, per_pend_q, hi_inc, per_inc, wc;
    logic [CW-1:0] pw_q, per_q;
    logic [DW-1:0] rem_q, num, sub;
    logic [7:0]    quo_q, angle_q;
    logic [3:0]    div_cnt_q;
    logic [2:0]    bit_idx;
    logic          take, valid_q, range_err_q, signal_lost_q;

`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILT_LEN - 1);
    logic          filt_q;
    logic [FW-1:0] run_q;
    // the filtered line flips only after FILT_LEN consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else if (sync2_q == filt_q) run_q <= '0;
        else if (run_q == FMAX) begin
            filt_q <= sync2_q;
            run_q  <= '0;
        end else run_q <= run_q + 1'b1;
    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    assign rise    = line & ~prev_q;
    assign fall    = ~line & prev_q;
    assign hi_inc  = (hi_cnt_q == TMO) ? hi_cnt_q : hi_cnt_q + 1'b1;
    assign per_inc = (per_cnt_q == TMO) ? per_cnt_q : per_cnt_q + 1'b1;
    assign wc      = (hi_lat_q < MINP) ? MINP : (hi_lat_q > MAXP) ? MAXP : hi_lat_q;
    assign num     = DW'(wc - MINP) * DW'(180);
    // div_cnt 9..2 walks quotient bits 7..0, value 1 is the publish cycle
    assign bit_idx = 3'(div_cnt_q - 4'd2);
    assign sub     = SPAN << bit_idx;
    assign take    = rem_q >= sub;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {sync1_q, sync2_q, prev_q} <= '0;
            state_q       <= IDLE;
            hi_cnt_q      <= '0;
            per_cnt_q     <= '0;
            hi_lat_q      <= '0;
            hi_pend_q     <= '0;
            per_pend_q    <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            div_cnt_q     <= '0;
            pw_q          <= '0;
            per_q         <= '0;
            angle_q       <= '0;
            valid_q       <= 1'b0;
            range_err_q   <= 1'b0;
            signal_lost_q <= 1'b1;
        end else begin
            {sync1_q, sync2_q, prev_q} <= {bus_io.pwm_in, sync1_q, line};
            valid_q <= 1'b0;
            if (div_cnt_q != 4'd0) div_cnt_q <= div_cnt_q - 1'b1;
            if (div_cnt_q > 4'd1) begin
                rem_q <= take ? rem_q - sub : rem_q;
                quo_q <= {quo_q[6:0], take};
            end
            if (div_cnt_q == 4'd1) begin
                valid_q       <= 1'b1;
                angle_q       <= quo_q;
                pw_q          <= hi_pend_q;
                per_q         <= per_pend_q;
                range_err_q   <= (hi_pend_q < MINP) || (hi_pend_q > MAXP);
                signal_lost_q <= 1'b0;
            end
            case (state_q)
                IDLE:
                    if (rise) begin
                        hi_cnt_q  <= CW'(1);
                        per_cnt_q <= CW'(1);
                        state_q   <= HIGH;
                    end
                HIGH: begin
                    hi_cnt_q  <= hi_inc;
                    per_cnt_q <= per_inc;
                    if (per_cnt_q == TMO) begin
                        state_q       <= LOST;
                        signal_lost_q <= 1'b1;
                    end else if (fall) begin
                        hi_lat_q <= hi_cnt_q;
                        state_q  <= LOW;
                    end
                end
                LOW:
                    if (rise) begin
                        hi_pend_q  <= hi_lat_q;
                        per_pend_q <= per_cnt_q;
                        rem_q      <= num;
                        quo_q      <= '0;
                        div_cnt_q  <= 4'd9;
                        hi_cnt_q   <= CW'(1);
                        per_cnt_q  <= CW'(1);
                        state_q    <= HIGH;
                    end else begin
                        per_cnt_q <= per_inc;
                        if (per_cnt_q == TMO) begin
                            state_q       <= LOST;
                            signal_lost_q <= 1'b1;
                        end
                    end
                default: state_q <= IDLE;
            endcase
        end

    assign bus_io.pulse_width = pw_q;
    assign bus_io.period      = per_q;
    assign bus_io.angle       = angle_q;
    assign bus_io.valid       = valid_q;
    assign bus_io.range_err   = range_err_q;
    assign bus_io.signal_lost = signal_lost_q;
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: timestamp-based model of edges, publishes and timeouts checked every cycle,
// plus literal spot checks of the published results after directed frame sequences.
module tb_servo_pwm_decoder;
    localparam int MINP = 100, MAXP = 200, TMO = 2500, CW = 12, FL = 4, HN = 1024;

    typedef struct {int due; int pw; int per; int ang; bit re;} pub_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0, checks = 0, errors = 0, nvalid = 0;

    servo_pwm_decoder_if #(.CW(CW)) bus ();
    servo_pwm_decoder #(.MIN_PULSE(MINP), .MAX_PULSE(MAXP), .TIMEOUT(TMO), .CW(CW), .FILT_LEN(FL))
        dut (.clk(clk), .rst(rst), .bus_io(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit   inh [HN];
    bit   eff [HN];
    pub_t pq[$];
    bit   armed, have_f, rise, fall, e_valid, e_re, e_lost, ok;
    int   c, r0, f, lost_cyc, e_pw, e_per, e_ang;

    function automatic int ang_of(int w);
        int wc;
        wc = (w < MINP) ? MINP : (w > MAXP) ? MAXP : w;
        return (wc - MINP) * 180 / (MAXP - MINP);
    endfunction

    // level seen by the decoder: input two cycles late, optionally debounced
    function automatic bit line_at(int cc);
`ifdef SERVO_DEC_GLITCH_FILTER_EN
        bit v, same;
        v = inh[(cc - 3) % HN];
        same = 1'b1;
        for (int k = 3; k < 3 + FL; k++) if (inh[(cc - k) % HN] != v) same = 1'b0;
        return same ? v : eff[(cc - 1) % HN];
`else
        return inh[(cc - 2) % HN];
`endif
    endfunction

    always @(negedge clk) begin
        c = cyc;
        inh[c % HN] = bus.pwm_in;
        if (rst) begin
            eff[c % HN] = 1'b0;
            pq.delete();
            armed = 0; have_f = 0; lost_cyc = -1;
            e_valid = 0; e_pw = 0; e_per = 0; e_ang = 0; e_re = 0; e_lost = 1;
        end else begin
            eff[c % HN] = line_at(c);
            rise = eff[c % HN] && !eff[(c - 1) % HN];
            fall = !eff[c % HN] && eff[(c - 1) % HN];
            e_valid = 0;
            if (pq.size() > 0 && pq[0].due == c) begin
                e_valid = 1; e_pw = pq[0].pw; e_per = pq[0].per; e_ang = pq[0].ang; e_re = pq[0].re;
                e_lost = 0;
                void'(pq.pop_front());
            end
            if (c == lost_cyc) e_lost = 1;
            if (rise && armed && have_f && c - r0 <= TMO) begin
                pq.push_back('{c + 10, f - r0, c - r0, ang_of(f - r0), (f - r0 < MINP) || (f - r0 > MAXP)});
                r0 = c; have_f = 0;
            end else if (armed && c - r0 >= TMO) begin
                armed = 0; lost_cyc = c + 1;
            end else if (rise && !armed && c != lost_cyc) begin
                armed = 1; r0 = c; have_f = 0;
            end else if (fall && armed) begin
                have_f = 1; f = c;
            end
            if (bus.valid === 1'b1) nvalid++;
        end
        ok = (bus.valid === e_valid) && (bus.pulse_width === CW'(e_pw)) && (bus.period === CW'(e_per)) &&
             (bus.angle === 8'(e_ang)) && (bus.range_err === e_re) && (bus.signal_lost === e_lost);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL model cycle %0d: got v=%0b pw=%0d per=%0d ang=%0d re=%0b lost=%0b want v=%0b pw=%0d per=%0d ang=%0d re=%0b lost=%0b",
                     c, bus.valid, bus.pulse_width, bus.period, bus.angle, bus.range_err, bus.signal_lost,
                     e_valid, e_pw, e_per, e_ang, e_re, e_lost);
        end
    end

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(bit v, int n);
        bus.pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(int w, int p);
        drive(1'b1, w);
        drive(1'b0, p - w);
    endtask

    task automatic expect_out(string name, int pw, int per, int ang, int re, int lost);
        chk({name, " pulse_width"}, int'(bus.pulse_width), pw);
        chk({name, " period"}, int'(bus.period), per);
        chk({name, " angle"}, int'(bus.angle), ang);
        chk({name, " range_err"}, int'(bus.range_err), re);
        chk({name, " signal_lost"}, int'(bus.signal_lost), lost);
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 1);
        chk("reset valid", int'(bus.valid), 0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;

        repeat (10) frame(150, 2000);
        chk("nominal valid count", nvalid, 9);
        expect_out("nominal", 150, 2000, 90, 0, 0);

        frame(100, 2000);
        frame(200, 2000);
        expect_out("min width", 100, 2000, 0, 0, 0);
        frame(250, 2000);
        expect_out("max width", 200, 2000, 180, 0, 0);
        frame(150, 2000);
        expect_out("over width", 250, 2000, 180, 1, 0);
        frame(50, 2000);
        expect_out("recover mid", 150, 2000, 90, 0, 0);
        frame(150, 2000);
        expect_out("under width", 50, 2000, 0, 1, 0);

        drive(1'b0, 3000);
        chk("stuck low lost", int'(bus.signal_lost), 1);
        frame(150, 2000);
        chk("first rise after lost", int'(bus.signal_lost), 1);
        frame(150, 2000);
        expect_out("low recovery", 150, 2000, 90, 0, 0);

        nvalid = 0;
        drive(1'b1, 3000);
        drive(1'b0, 1000);
        chk("stuck high lost", int'(bus.signal_lost), 1);
        chk("stuck high valid count", nvalid, 1);
        frame(170, 2000);
        frame(150, 2000);
        expect_out("high recovery", 170, 2000, 126, 0, 0);

        drive(1'b1, 8);
        #1 rst = 1'b1;
        #1;
        expect_out("async reset", 0, 0, 0, 0, 1);
        chk("async reset valid", int'(bus.valid), 0);
        bus.pwm_in = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        nvalid = 0;
        drive(1'b0, 30);
        chk("no stray valid", nvalid, 0);
        frame(120, 1500);
        frame(150, 2000);
        expect_out("reset recovery", 120, 1500, 36, 0, 0);

`ifdef SERVO_DEC_GLITCH_FILTER_EN
        drive(1'b1, 180);
        drive(1'b0, 600);
        drive(1'b1, 2);
        drive(1'b0, 1218);
        frame(150, 2000);
        expect_out("glitch", 180, 2000, 144, 0, 0);
`endif

        repeat (20) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
